// File: rtl/encoder_mac_sequencer.sv
// encoder_mac_sequencer
//   Computes the encoder layer y[j] = b[j] + sum_i x[i]*w[j][i] on a single
//   shared multiply-accumulate lane. One input vector is latched, the weight
//   memory is walked in order (j outer, i inner), and the M_output results are
//   handed to the next layer through a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   x and b are valid
//   in_ready   block accepts a vector (registered)
//   x          input vector, x[i] at [i*BITSIZE +: BITSIZE]
//   b          bias vector, b[j] at [j*BITSIZE +: BITSIZE]
//   w_rd_en    weight memory read strobe
//   w_addr     weight address = j*N_input + i
//   w_data     w[j][i], valid one cycle after w_rd_en
//   out_valid  results are valid
//   out_ready  downstream accepts the results
//   out        y[j] at [j*BITSIZE +: BITSIZE]
//   busy       high in any state other than IDLE
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// LOAD  | seed accumulator with b[j], first weight read of row j in flight
// MAC   | accumulate x[i]*w[j][i], prefetching w[j][i+1]
// DONE  | results presented, waiting for out_ready
module encoder_mac_sequencer #(
    parameter int N_input  = 9,
    parameter int M_output = 4,
    parameter int BITSIZE  = 32,
    parameter int FRAC     = 16,
    parameter int ADDR_W   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_input*BITSIZE-1:0]    x,
    input  logic [M_output*BITSIZE-1:0]   b,
    output logic                          w_rd_en,
    output logic [ADDR_W-1:0]             w_addr,
    input  logic [BITSIZE-1:0]            w_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [M_output*BITSIZE-1:0]   out,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    localparam int IW = (N_input  > 1) ? $clog2(N_input)  : 1;
    localparam int JW = (M_output > 1) ? $clog2(M_output) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_input - 1);
    localparam logic [JW-1:0] J_LAST = JW'(M_output - 1);

    state_t                        state;
    logic [IW-1:0]                 i;
    logic [JW-1:0]                 j;
    logic [BITSIZE-1:0]            acc;
    logic [N_input*BITSIZE-1:0]    x_r;
    logic [M_output*BITSIZE-1:0]   b_r;

    logic [BITSIZE-1:0] x_sel;
    logic [BITSIZE-1:0] b_sel;
    logic [BITSIZE-1:0] prod_term;
    logic [BITSIZE-1:0] acc_sum;

    // Fixed-point multiply: full-width signed product, arithmetic shift
    // (floor), keep the low word so overflow wraps.
    function automatic logic [BITSIZE-1:0] mul(input logic [BITSIZE-1:0] a,
                                               input logic [BITSIZE-1:0] c);
        logic signed [2*BITSIZE-1:0] p;
        p = $signed(a) * $signed(c);
        p = p >>> FRAC;
        return p[BITSIZE-1:0];
    endfunction

    assign x_sel     = x_r[i*BITSIZE +: BITSIZE];
    assign b_sel     = b_r[j*BITSIZE +: BITSIZE];
    assign prod_term = mul(x_sel, w_data);
    assign acc_sum   = acc + prod_term;
    assign busy      = (state != IDLE);

    // Reads are issued one cycle ahead of use; since they are strictly
    // sequential, each new address is simply the previous one plus one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            acc       <= '0;
            x_r       <= '0;
            b_r       <= '0;
            in_ready  <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        x_r      <= x;
                        b_r      <= b;
                        j        <= '0;
                        i        <= '0;
                        w_rd_en  <= 1'b1;
                        w_addr   <= '0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    acc <= b_sel;
                    i   <= '0;
                    if (I_LAST != '0) begin
                        w_rd_en <= 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end else begin
                        w_rd_en <= 1'b0;
                    end
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_sum;
                    if (i != I_LAST) begin
                        i <= i + 1'b1;
                        // the read for element i+2 exists only if i+1 is not the last
                        if ((i + 1'b1) != I_LAST) begin
                            w_rd_en <= 1'b1;
                            w_addr  <= w_addr + 1'b1;
                        end else begin
                            w_rd_en <= 1'b0;
                        end
                    end else begin
                        out[j*BITSIZE +: BITSIZE] <= acc_sum;
                        if (j != J_LAST) begin
                            j       <= j + 1'b1;
                            w_rd_en <= 1'b1;
                            w_addr  <= w_addr + 1'b1;
                            state   <= LOAD;
                        end else begin
                            w_rd_en   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_mac_sequencer.sv
module tb_encoder_mac_sequencer;
    localparam int N  = 9;
    localparam int M  = 4;
    localparam int BS = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*BS-1:0]   x = '0;
    logic [M*BS-1:0]   b = '0;
    logic              w_rd_en;
    logic [5:0]        w_addr;
    logic [BS-1:0]     w_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [M*BS-1:0]   out;
    logic              busy;

    encoder_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .b(b), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] w_mem [0:63];
    always @(posedge clk) w_data <= w_rd_en ? w_mem[w_addr] : $urandom();

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [M*BS-1:0] y;
        int              acc_cyc;
    } exp_t;
    exp_t sb[$];

    int   exp_addr = 0;
    int   rd_cnt = 0;
    bit   hold_ready = 1'b0;
    bit   seen_valid = 1'b0;
    logic [M*BS-1:0] prev_out = '0;

    task automatic chk(input string nm, input logic [M*BS-1:0] act, input logic [M*BS-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: Q16.16 product floored toward -inf using integer division.
    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] c);
        longint p;
        longint q;
        logic [63:0] qv;
        p = longint'($signed(a)) * longint'($signed(c));
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        qv = q;
        return qv[31:0];
    endfunction

    function automatic logic [M*BS-1:0] model(input logic [N*BS-1:0] xv, input logic [M*BS-1:0] bv);
        logic [M*BS-1:0] y;
        logic [31:0] s;
        y = '0;
        for (int jj = 0; jj < M; jj++) begin
            s = bv[jj*BS +: BS];
            for (int ii = 0; ii < N; ii++)
                s = s + fx_mul(xv[ii*BS +: BS], w_mem[jj*N + ii]);
            y[jj*BS +: BS] = s;
        end
        return y;
    endfunction

    // Monitor: memory traffic, handshake behaviour and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
        end else begin
            if (w_rd_en) begin
                chk("rd_addr", w_addr, exp_addr);
                chk("rd_phase", {busy, out_valid}, 2'b10);
                exp_addr++;
                rd_cnt++;
            end
            if (out_valid) begin
                chk("in_ready_done", in_ready, 0);
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    if (sb.size() == 0) fail_now("unexpected_out_valid");
                    else chk("latency", cyc - sb[0].acc_cyc, 40);
                    chk("read_count", rd_cnt, 36);
                end else begin
                    chk("out_stable", out, prev_out);
                end
                if (out_ready) begin
                    if (sb.size() > 0) begin
                        chk("y", out, sb[0].y);
                        void'(sb.pop_front());
                    end
                    seen_valid = 1'b0;
                end
            end
            prev_out = out;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready && !busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!(in_ready && !busy)) fail_now("idle_timeout");
    endtask

    task automatic send(input logic [N*BS-1:0] xv, input logic [M*BS-1:0] bv,
                        input logic [M*BS-1:0] yexp);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            return;
        end
        x = xv;
        b = bv;
        in_valid = 1'b1;
        e.y = yexp;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        exp_addr = 0;
        rd_cnt = 0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) x[k*BS +: BS] = $urandom();
        for (int k = 0; k < M; k++) b[k*BS +: BS] = $urandom();
    endtask

    task automatic fill_w_random();
        for (int k = 0; k < 64; k++) w_mem[k] = $urandom();
    endtask

    logic [N*BS-1:0] xv;
    logic [M*BS-1:0] bv;
    logic [M*BS-1:0] y45;

    initial begin
        for (int k = 0; k < 64; k++) w_mem[k] = 32'h0;
        for (int k = 0; k < M; k++) y45[k*BS +: BS] = 32'h0004_8000;

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // case 1: all ones times 0.5
        wait_idle();
        for (int k = 0; k < 64; k++) w_mem[k] = 32'h0000_8000;
        for (int k = 0; k < N; k++) xv[k*BS +: BS] = 32'h0001_0000;
        send(xv, '0, y45);

        // case 2: -2.0 * 1.5 + 0.25
        wait_idle();
        fill_w_random();
        for (int k = 0; k < M; k++) w_mem[k*N] = 32'h0001_8000;
        xv = '0;
        xv[BS-1:0] = 32'hFFFE_0000;
        for (int k = 0; k < M; k++) bv[k*BS +: BS] = 32'h0000_4000;
        send(xv, bv, {M{32'hFFFD_4000}});

        // case 3: floor of a tiny negative product
        wait_idle();
        for (int k = 0; k < 64; k++) w_mem[k] = 32'h0;
        for (int k = 0; k < M; k++) w_mem[k*N] = 32'h0000_8000;
        xv = '0;
        xv[BS-1:0] = 32'hFFFF_FFFF;
        send(xv, '0, {M{32'hFFFF_FFFF}});

        // case 4: stall in DONE while in_valid is pulsed
        wait_idle();
        fill_w_random();
        hold_ready = 1'b1;
        for (int k = 0; k < N; k++) xv[k*BS +: BS] = $urandom();
        for (int k = 0; k < M; k++) bv[k*BS +: BS] = $urandom();
        send(xv, bv, model(xv, bv));
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) fail_now("out_valid_timeout");
        end
        for (int k = 0; k < N; k++) xv[k*BS +: BS] = $urandom();
        for (int k = 0; k < M; k++) bv[k*BS +: BS] = $urandom();
        x = xv;
        b = bv;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0] | (c == 9);
            chk("busy_in_done", {busy, out_valid}, 2'b11);
            @(negedge clk);
        end
        hold_ready = 1'b0;
        send(xv, bv, model(xv, bv));

        // case 6: reset in the middle of a vector
        wait_idle();
        for (int k = 0; k < 64; k++) w_mem[k] = 32'h0000_8000;
        for (int k = 0; k < N; k++) xv[k*BS +: BS] = 32'h0001_0000;
        send(xv, '0, y45);
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out", out, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", w_rd_en, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(xv, '0, y45);

        // randomized vectors
        for (int v = 0; v < 15; v++) begin
            wait_idle();
            fill_w_random();
            for (int k = 0; k < N; k++) xv[k*BS +: BS] = $urandom();
            for (int k = 0; k < M; k++) bv[k*BS +: BS] = $urandom();
            send(xv, bv, model(xv, bv));
        end

        begin
            int t;
            t = 0;
            while ((sb.size() != 0 || busy) && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (sb.size() != 0) fail_now("drain_timeout");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
